// File: rtl/mrr_pathway_pkg.sv
// Shared types and constants for the MRR pathway scheduler and its per-pathway FSMs.
// Holds the FSM state encoding, flush length and timeout-counter width.
package mrr_pathway_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASSIGNED = 2'd1,
        ST_DECODING = 2'd2,
        ST_FLUSH    = 2'd3
    } path_state_e;

    localparam int FLUSH_CYCLES  = 2;
    localparam int FLUSH_CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TIMEOUT_CNT_W = 8;
    localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_CNT_MAX = '1;

endpackage

// File: rtl/mrr_pathway_fsm.sv
// One decode pathway: IDLE/ASSIGNED/DECODING/FLUSH lifecycle plus watchdog; outputs registered.
// o_expire is a same-cycle pulse for an expiry that actually causes the flush.
module mrr_pathway_fsm
    import mrr_pathway_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_accept,
    input  logic                     i_preempt,
    input  logic                     currently_decoding,
    input  logic                     decode_done,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_len,
    output path_state_e              o_state,
    output logic                     o_pathway_reset,
    output logic                     o_busy,
    output logic                     o_expire
);

    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_ONE   = 1;
    localparam logic [FLUSH_CNT_W-1:0]   FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_CNT_W-1:0]   FLUSH_ONE  = 1;

    path_state_e              state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
    logic [FLUSH_CNT_W-1:0]   flush_q, flush_d;
    logic                     prst_q, prst_d;
    logic                     busy_q, busy_d;
    logic                     active, expire;

    always_comb begin
        active   = (state_q == ST_ASSIGNED) || (state_q == ST_DECODING);
        expire   = active && (timeout_len != '0) && (wdog_q == timeout_len - WDOG_ONE);
        // A coincident decode_done or a preemption claims the transition, so no expiry is counted.
        o_expire = expire && !decode_done && !i_accept;

        state_d = state_q;
        wdog_d  = active ? wdog_q + WDOG_ONE : wdog_q;
        flush_d = flush_q;
        prst_d  = 1'b0;

        if (i_accept) begin
            state_d = ST_ASSIGNED;
            wdog_d  = '0;
            prst_d  = i_preempt;
        end else begin
            case (state_q)
                ST_ASSIGNED, ST_DECODING: begin
                    if (decode_done || expire) begin
                        state_d = ST_FLUSH;
                        flush_d = '0;
                        prst_d  = 1'b1;
                    end else if (state_q == ST_ASSIGNED && currently_decoding) begin
                        state_d = ST_DECODING;
                        wdog_d  = '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == FLUSH_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        flush_d = flush_q + FLUSH_ONE;
                        prst_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wdog_q  <= '0;
            flush_q <= '0;
            prst_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            flush_q <= flush_d;
            prst_q  <= prst_d;
            busy_q  <= busy_d;
        end
    end

    assign o_state         = state_q;
    assign o_pathway_reset = prst_q;
    assign o_busy          = busy_q;

endmodule

// File: rtl/mrr_pathway_scheduler.sv
// Round-robin dispatch of header detections onto NUM_PATHWAYS decoders; assignment strobe 1 cycle after accept.
// det_ready is combinational (any IDLE pathway, or a weaker ASSIGNED one when MRR_PATHWAY_PREEMPT_EN is defined).
module mrr_pathway_scheduler
    import mrr_pathway_pkg::*;
#(
    parameter int NUM_PATHWAYS  = 4,
    parameter int CORR_WIDTH    = 16,
    parameter int CFO_IDX_WIDTH = 10,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     det_valid,
    output logic                     det_ready,
    input  logic [CORR_WIDTH-1:0]    det_corr,
    input  logic [CFO_IDX_WIDTH-1:0] det_cfo_idx,
    output logic [NUM_PATHWAYS-1:0]  o_assign_valid,
    output logic [CORR_WIDTH-1:0]    o_assign_corr,
    output logic [CFO_IDX_WIDTH-1:0] o_assign_cfo_idx,
    input  logic [NUM_PATHWAYS-1:0]  currently_decoding,
    input  logic [NUM_PATHWAYS-1:0]  decode_done,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_len,
    output logic [NUM_PATHWAYS-1:0]  o_pathway_reset,
    output logic [NUM_PATHWAYS-1:0]  o_busy,
    output logic [TIMEOUT_CNT_W-1:0] o_timeout_cnt
);

    localparam int PTR_W = (NUM_PATHWAYS > 1) ? $clog2(NUM_PATHWAYS) : 1;
    localparam logic [PTR_W:0]   NUM_P  = (PTR_W + 1)'(NUM_PATHWAYS);
    localparam logic [PTR_W-1:0] LAST_P = PTR_W'(NUM_PATHWAYS - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam int SUM_W = TIMEOUT_CNT_W + 1;

    path_state_e               st [NUM_PATHWAYS];
    logic [NUM_PATHWAYS-1:0]   idle, expire, accept_vec, preempt_vec;
    logic [PTR_W-1:0]          ptr_q, ptr_d, sel_idx, tgt_idx;
    logic [PTR_W:0]            scan;
    logic                      sel_found, can_preempt, accept;
    logic [NUM_PATHWAYS-1:0]   assign_vld_q, assign_vld_d;
    logic [CORR_WIDTH-1:0]     assign_corr_q, assign_corr_d;
    logic [CFO_IDX_WIDTH-1:0]  assign_cfo_q, assign_cfo_d;
    logic [TIMEOUT_CNT_W-1:0]  tmo_q, tmo_d;
    logic [3:0]                n_exp;
    logic [SUM_W-1:0]          tmo_sum;

`ifdef MRR_PATHWAY_PREEMPT_EN
    logic [CORR_WIDTH-1:0]     path_corr_q [NUM_PATHWAYS];
    logic [CORR_WIDTH-1:0]     path_corr_d [NUM_PATHWAYS];
    logic [NUM_PATHWAYS-1:0]   assigned;
    logic                      pre_found;
    logic [PTR_W-1:0]          pre_idx;
    logic [CORR_WIDTH-1:0]     min_corr;
`endif

    // First IDLE pathway at or after the pointer, wrapping.
    always_comb begin
        idle      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_PATHWAYS; i++) begin
            idle[i] = (st[i] == ST_IDLE);
        end
        for (int k = 0; k < NUM_PATHWAYS; k++) begin
            scan = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (scan >= NUM_P) begin
                scan = scan - NUM_P;
            end
            if (!sel_found && idle[scan[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan[PTR_W-1:0];
            end
        end
    end

`ifdef MRR_PATHWAY_PREEMPT_EN
    // Weakest ASSIGNED pathway; strict '<' keeps the lowest index on ties.
    always_comb begin
        assigned  = '0;
        pre_found = 1'b0;
        pre_idx   = '0;
        min_corr  = '0;
        for (int i = 0; i < NUM_PATHWAYS; i++) begin
            assigned[i] = (st[i] == ST_ASSIGNED);
            if (assigned[i] && (!pre_found || path_corr_q[i] < min_corr)) begin
                pre_found = 1'b1;
                pre_idx   = PTR_W'(i);
                min_corr  = path_corr_q[i];
            end
        end
        can_preempt = !sel_found && pre_found && (det_corr > min_corr);
        tgt_idx     = sel_found ? sel_idx : pre_idx;
    end
`else
    always_comb begin
        can_preempt = 1'b0;
        tgt_idx     = sel_idx;
    end
`endif

    assign det_ready = sel_found | can_preempt;
    assign accept    = det_valid & det_ready;

    always_comb begin
        accept_vec           = '0;
        preempt_vec          = '0;
        accept_vec[tgt_idx]  = accept;
        preempt_vec[tgt_idx] = accept & can_preempt;

        ptr_d         = ptr_q;
        assign_corr_d = assign_corr_q;
        assign_cfo_d  = assign_cfo_q;
        assign_vld_d  = accept_vec;
        if (accept) begin
            ptr_d         = (tgt_idx == LAST_P) ? '0 : tgt_idx + PTR_ONE;
            assign_corr_d = det_corr;
            assign_cfo_d  = det_cfo_idx;
        end

        n_exp = '0;
        for (int i = 0; i < NUM_PATHWAYS; i++) begin
            n_exp = n_exp + {3'b000, expire[i]};
        end
        tmo_sum = {1'b0, tmo_q} + SUM_W'(n_exp);
        tmo_d   = (tmo_sum > {1'b0, TIMEOUT_CNT_MAX}) ? TIMEOUT_CNT_MAX : tmo_sum[TIMEOUT_CNT_W-1:0];
    end

`ifdef MRR_PATHWAY_PREEMPT_EN
    always_comb begin
        for (int i = 0; i < NUM_PATHWAYS; i++) begin
            path_corr_d[i] = accept_vec[i] ? det_corr : path_corr_q[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q         <= '0;
            assign_vld_q  <= '0;
            assign_corr_q <= '0;
            assign_cfo_q  <= '0;
            tmo_q         <= '0;
`ifdef MRR_PATHWAY_PREEMPT_EN
            for (int i = 0; i < NUM_PATHWAYS; i++) begin
                path_corr_q[i] <= '0;
            end
`endif
        end else begin
            ptr_q         <= ptr_d;
            assign_vld_q  <= assign_vld_d;
            assign_corr_q <= assign_corr_d;
            assign_cfo_q  <= assign_cfo_d;
            tmo_q         <= tmo_d;
`ifdef MRR_PATHWAY_PREEMPT_EN
            for (int i = 0; i < NUM_PATHWAYS; i++) begin
                path_corr_q[i] <= path_corr_d[i];
            end
`endif
        end
    end

    for (genvar g = 0; g < NUM_PATHWAYS; g++) begin : g_path
        mrr_pathway_fsm #(
            .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
        ) u_fsm (
            .clk               (clk),
            .rst               (rst),
            .i_accept          (accept_vec[g]),
            .i_preempt         (preempt_vec[g]),
            .currently_decoding(currently_decoding[g]),
            .decode_done       (decode_done[g]),
            .timeout_len       (timeout_len),
            .o_state           (st[g]),
            .o_pathway_reset   (o_pathway_reset[g]),
            .o_busy            (o_busy[g]),
            .o_expire          (expire[g])
        );
    end

    assign o_assign_valid   = assign_vld_q;
    assign o_assign_corr    = assign_corr_q;
    assign o_assign_cfo_idx = assign_cfo_q;
    assign o_timeout_cnt    = tmo_q;

endmodule

// File: tb/tb_mrr_pathway_scheduler.sv
// Scoreboard bench for mrr_pathway_scheduler: directed scenarios then random traffic against a behavioural model.
module tb_mrr_pathway_scheduler;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int FW = 10;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          det_valid;
    logic          det_ready;
    logic [CW-1:0] det_corr;
    logic [FW-1:0] det_cfo_idx;
    logic [N-1:0]  o_assign_valid;
    logic [CW-1:0] o_assign_corr;
    logic [FW-1:0] o_assign_cfo_idx;
    logic [N-1:0]  currently_decoding;
    logic [N-1:0]  decode_done;
    logic [TW-1:0] timeout_len;
    logic [N-1:0]  o_pathway_reset;
    logic [N-1:0]  o_busy;
    logic [7:0]    o_timeout_cnt;

    always #5 clk = ~clk;

    mrr_pathway_scheduler #(
        .NUM_PATHWAYS(N), .CORR_WIDTH(CW), .CFO_IDX_WIDTH(FW), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .det_valid(det_valid), .det_ready(det_ready),
        .det_corr(det_corr), .det_cfo_idx(det_cfo_idx),
        .o_assign_valid(o_assign_valid), .o_assign_corr(o_assign_corr),
        .o_assign_cfo_idx(o_assign_cfo_idx),
        .currently_decoding(currently_decoding), .decode_done(decode_done),
        .timeout_len(timeout_len),
        .o_pathway_reset(o_pathway_reset), .o_busy(o_busy),
        .o_timeout_cnt(o_timeout_cnt)
    );

    typedef struct packed {
        logic [N-1:0]  oh;
        logic [CW-1:0] corr;
        logic [FW-1:0] cfo;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   errors  = 0;

    // Behavioural model: 0 idle, 1 assigned, 2 decoding, 3 flush.
    int           mst [N];
    int           mage[N];
    int           mfl [N];
    int           mcorr[N];
    int           mptr;
    int           mtmo;
    logic [N-1:0] exp_rst;
    logic [N-1:0] exp_busy;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mst[i] = 0; mage[i] = 0; mfl[i] = 0; mcorr[i] = 0;
        end
        mptr = 0; mtmo = 0; exp_rst = '0; exp_busy = '0;
    endfunction

    // Evaluates one clock cycle with the currently driven inputs; returns 1ns after the edge.
    task automatic step();
        int   tgt;
        bit   pre, acc, ex;
        exp_t e;
        @(negedge clk);
        tgt = -1;
        pre = 0;
        for (int k = 0; k < N; k++) begin
            if (tgt < 0 && mst[(mptr + k) % N] == 0) tgt = (mptr + k) % N;
        end
`ifdef MRR_PATHWAY_PREEMPT_EN
        if (tgt < 0) begin
            int mi = -1;
            for (int i = 0; i < N; i++)
                if (mst[i] == 1 && (mi < 0 || mcorr[i] < mcorr[mi])) mi = i;
            if (mi >= 0 && int'(det_corr) > mcorr[mi]) begin
                tgt = mi;
                pre = 1;
            end
        end
`endif
        check("det_ready", longint'(det_ready), longint'(tgt >= 0));
        acc = rst && det_valid && (tgt >= 0);
        for (int i = 0; i < N; i++) begin
            exp_rst[i] = 1'b0;
            if (acc && i == tgt) begin
                mst[i] = 1; mage[i] = 0; mcorr[i] = int'(det_corr); exp_rst[i] = pre;
            end else if (mst[i] == 1 || mst[i] == 2) begin
                ex = (timeout_len != 0) && (mage[i] == int'(timeout_len) - 1);
                if (decode_done[i]) begin
                    mst[i] = 3; mfl[i] = 2; exp_rst[i] = 1'b1;
                end else if (ex) begin
                    mst[i] = 3; mfl[i] = 2; exp_rst[i] = 1'b1;
                    if (mtmo < 255) mtmo++;
                end else if (mst[i] == 1 && currently_decoding[i]) begin
                    mst[i] = 2; mage[i] = 0;
                end else begin
                    mage[i] = (mage[i] + 1) % 65536;
                end
            end else if (mst[i] == 3) begin
                mfl[i]--;
                if (mfl[i] == 0) mst[i] = 0;
                else exp_rst[i] = 1'b1;
            end
            exp_busy[i] = (mst[i] != 0);
        end
        if (acc) begin
            mptr = (tgt + 1) % N;
            e.oh = '0;
            e.oh[tgt] = 1'b1;
            e.corr = det_corr;
            e.cfo = det_cfo_idx;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int corr, input int cfo);
        det_valid   = 1'b1;
        det_corr    = CW'(corr);
        det_cfo_idx = FW'(cfo);
        step();
        det_valid   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        det_valid = 1'b0;
        repeat (n) step();
    endtask

    // Asserts reset away from the monitor's sample point, checks outputs clear at once, then releases.
    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        check("rst_assign_valid", longint'(o_assign_valid), 0);
        check("rst_assign_corr", longint'(o_assign_corr), 0);
        check("rst_assign_cfo", longint'(o_assign_cfo_idx), 0);
        check("rst_busy", longint'(o_busy), 0);
        check("rst_pathway_reset", longint'(o_pathway_reset), 0);
        check("rst_timeout_cnt", longint'(o_timeout_cnt), 0);
        model_reset();
        sbq.delete();
        idle_cycles(2);
        rst = 1'b1;
    endtask

    // Monitor: pops expected assignments whenever the DUT strobes, and checks per-cycle status.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (o_assign_valid != '0) begin
                if (sbq.size() == 0) begin
                    check("assign_unexpected", longint'(o_assign_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    check("assign_onehot", longint'(o_assign_valid), longint'(e.oh));
                    check("assign_corr", longint'(o_assign_corr), longint'(e.corr));
                    check("assign_cfo", longint'(o_assign_cfo_idx), longint'(e.cfo));
                end
            end
            check("assign_pending", longint'(sbq.size()), 0);
            sbq.delete();
            check("pathway_reset", longint'(o_pathway_reset), longint'(exp_rst));
            check("busy", longint'(o_busy), longint'(exp_busy));
            check("timeout_cnt", longint'(o_timeout_cnt), longint'(mtmo));
        end
    end

    initial begin
        logic [N-1:0] d;
        rst = 1'b0;
        det_valid = 1'b0; det_corr = '0; det_cfo_idx = '0;
        currently_decoding = '0; decode_done = '0; timeout_len = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Four back-to-back detections fill every pathway, then det_ready drops.
        for (int i = 0; i < 4; i++) offer(100 + i, 7 * i + 1);
        offer(55, 3);
        idle_cycles(2);

        // Done on 2 refills it (pointer -> 3); done on 1 with others busy, offered through its flush.
        decode_done = 4'b0100; step(); decode_done = '0;
        det_valid = 1'b1; det_corr = 16'd77; det_cfo_idx = 10'd9;
        repeat (3) step();
        det_valid = 1'b0;
        decode_done = 4'b0010; step(); decode_done = '0;
        det_valid = 1'b1; det_corr = 16'd88; det_cfo_idx = 10'd11;
        repeat (3) step();
        det_valid = 1'b0;
        idle_cycles(2);

        // Watchdog at 100 with no decode activity.
        do_reset();
        timeout_len = 16'd100;
        offer(300, 5);
        idle_cycles(105);

        // decode_done landing exactly on the expiry cycle.
        timeout_len = 16'd20;
        offer(301, 6);
        idle_cycles(19);
        decode_done = 4'b0010; step(); decode_done = '0;
        idle_cycles(4);

        // Reset while a pathway is decoding.
        timeout_len = '0;
        offer(302, 7);
        currently_decoding = 4'b0100; step(); currently_decoding = '0;
        idle_cycles(3);
        do_reset();
        offer(303, 8);
        idle_cycles(2);

`ifdef MRR_PATHWAY_PREEMPT_EN
        do_reset();
        offer(10, 1); offer(20, 2); offer(5, 3); offer(30, 4);
        offer(8, 5);
        offer(4, 6);
        idle_cycles(2);
`endif

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0)
                timeout_len = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(5, 60));
            det_valid   = $urandom_range(0, 1) == 1;
            det_corr    = CW'($urandom_range(0, 63));
            det_cfo_idx = FW'($urandom);
            currently_decoding = N'($urandom & $urandom);
            for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 15) == 0);
            decode_done = d;
            step();
        end
        det_valid = 1'b0; decode_done = '0; currently_decoding = '0;
        idle_cycles(3);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mrr_pathway_scheduler.md
MRR_PATHWAY_SCHEDULER -- requirements
Module: mrr_pathway_scheduler

Interface
REQ-001 SHALL have parameter NUM_PATHWAYS, default 4, number of decode pathways (2..8).
REQ-002 SHALL have parameter CORR_WIDTH, default 16, detection correlation magnitude width.
REQ-003 SHALL have parameter CFO_IDX_WIDTH, default 10, CFO bin index width.
REQ-004 SHALL have parameter TIMEOUT_WIDTH, default 16, watchdog counter width.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port det_valid  in  1  header detection offered.
REQ-008 SHALL have port det_ready  out  1  detection accepted when high with det_valid.
REQ-009 SHALL have port det_corr  in  CORR_WIDTH  detection correlation value.
REQ-010 SHALL have port det_cfo_idx  in  CFO_IDX_WIDTH  detection CFO bin.
REQ-011 SHALL have port o_assign_valid  out  NUM_PATHWAYS  one-hot assignment strobe.
REQ-012 SHALL have port o_assign_corr  out  CORR_WIDTH  correlation of the latest assignment.
REQ-013 SHALL have port o_assign_cfo_idx  out  CFO_IDX_WIDTH  CFO bin of the latest assignment.
REQ-014 SHALL have port currently_decoding  in  NUM_PATHWAYS  per-pathway decode-active flag.
REQ-015 SHALL have port decode_done  in  NUM_PATHWAYS  per-pathway end-of-packet pulse.
REQ-016 SHALL have port timeout_len  in  TIMEOUT_WIDTH  watchdog cycles; 0 disables the watchdog.
REQ-017 SHALL have port o_pathway_reset  out  NUM_PATHWAYS  per-pathway reset to the correlator and loopback.
REQ-018 SHALL have port o_busy  out  NUM_PATHWAYS  pathway state not IDLE.
REQ-019 SHALL have port o_timeout_cnt  out  8  saturating count of watchdog expiries.

Function
REQ-020 SHALL run one FSM per pathway with states IDLE, ASSIGNED, DECODING and FLUSH.
REQ-021 IDLE->ASSIGNED SHALL occur on acceptance; ASSIGNED->DECODING on currently_decoding high; ASSIGNED or DECODING->FLUSH on decode_done or watchdog expiry; FLUSH->IDLE after exactly 2 cycles.
REQ-022 o_pathway_reset[i] SHALL be high for both FLUSH cycles and low otherwise.
REQ-023 det_ready SHALL be combinational: high iff any pathway is IDLE (or preemptable per REQ-032).
REQ-024 On acceptance the scheduler SHALL select the first IDLE pathway at or after the round-robin pointer, wrapping modulo NUM_PATHWAYS; the pointer then becomes selected+1 mod NUM_PATHWAYS.
REQ-025 o_assign_valid SHALL pulse one cycle, 1 cycle after acceptance; o_assign_corr/o_assign_cfo_idx SHALL be registered at acceptance and held until the next acceptance.
REQ-026 Watchdog SHALL load 0 on entering ASSIGNED or DECODING and increment each cycle; expiry at count == timeout_len-1 when timeout_len != 0.
REQ-027 Simultaneous decode_done and expiry SHALL give one FLUSH and SHALL NOT increment o_timeout_cnt; o_timeout_cnt SHALL saturate at 255.
REQ-028 decode_done or currently_decoding in IDLE or FLUSH SHALL be ignored; a pathway leaving FLUSH SHALL NOT be selectable until the following cycle.
REQ-029 At most one detection SHALL be accepted per cycle.
REQ-030 Each pathway's accepted det_corr SHALL be stored per pathway for REQ-032.

Reset
REQ-031 Asserted rst SHALL force all FSMs to IDLE, pointer 0, counters 0, and every output low/zero except det_ready, which follows REQ-023 (high once rst releases).

Configuration
REQ-032 With MRR_PATHWAY_PREEMPT_EN defined: when no pathway is IDLE, det_ready SHALL be high if det_corr exceeds the stored corr of some ASSIGNED pathway; acceptance SHALL target the lowest-corr ASSIGNED pathway (lowest index on tie), pulse its o_pathway_reset for 1 cycle, and then re-enter ASSIGNED with the new detection.
REQ-033 Without MRR_PATHWAY_PREEMPT_EN: no preemption; DECODING is never interrupted except by decode_done or the watchdog; per-pathway corr storage SHALL be omitted.

Structure
REQ-034 The FSM state encoding, FLUSH_CYCLES=2 and the o_timeout_cnt width SHALL live in package mrr_pathway_pkg.
REQ-035 The per-pathway FSM plus watchdog SHALL be sub-module mrr_pathway_fsm, generate-instantiated NUM_PATHWAYS times; selection and pointer logic SHALL remain at the top level.

Verification
REQ-036 Four back-to-back detections, all idle -> o_assign_valid = 0001, 0010, 0100, 1000 on consecutive cycles, then det_ready=0.
REQ-037 Pathway 1 decode_done with pointer at 3, others busy -> o_pathway_reset[1] high 2 cycles; next detection -> o_assign_valid=0010.
REQ-038 timeout_len=100, no currently_decoding -> FLUSH entered 100 cycles after assignment, o_timeout_cnt=1.
REQ-039 decode_done coincident with expiry -> single 2-cycle FLUSH, o_timeout_cnt unchanged.
REQ-040 rst asserted mid-DECODING -> outputs cleared immediately; after release det_ready=1 and first assignment goes to 0001.
REQ-041 PREEMPT_EN, all ASSIGNED with corr 10,20,5,30, det_corr=8 -> pathway 2 preempted (1-cycle reset), o_assign_valid=0100; det_corr=4 -> det_ready=0.
